// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int PktCountWidth = 16;

    // Round-robin winner: first set bit of valid at or above ptr, wrapping modulo numReq.
    // Written for up to 8 requesters; callers zero-extend narrower vectors.
    // The request vector is rotated so that ptr lands on bit 0, the lowest set bit is
    // found, and the offset is added back to ptr modulo numReq.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input logic [3:0] numReq
    );
        logic [7:0] rot;
        logic [3:0] idx;
        logic [3:0] first;
        logic [3:0] sum;
        rot   = 8'd0;
        first = 4'd0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= numReq) begin
                idx = idx - numReq;
            end else begin
                idx = idx;
            end
            if (4'(k) < numReq) begin
                rot[k] = valid[idx[2:0]];
            end else begin
                rot[k] = 1'b0;
            end
        end
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) begin
                first = 4'(k);
            end else begin
                first = first;
            end
        end
        sum = {1'b0, ptr} + first;
        if (sum >= numReq) begin
            sum = sum - numReq;
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotate, priority-encode, un-rotate.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdW-1:0]    ptr,
    output logic [IdW-1:0]    winner,
    output logic              anyValid
);

    logic [7:0] valid8_s;
    logic [2:0] ptr3_s;
    logic [2:0] pick3_s;

    assign valid8_s = 8'(valid);
    assign ptr3_s   = 3'(ptr);
    assign pick3_s  = rr_pick(valid8_s, ptr3_s, 4'(NumReq));
    assign winner   = IdW'(pick3_s);
    assign anyValid = |valid;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing the fifo_top write port among NumReq producers.
// A grant is held from the first beat of a packet until its last beat is accepted.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumReq    = 2,
    localparam int IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NumReq*DataWidth-1:0] reqData,
    input  logic [NumReq-1:0]           reqValid,
    input  logic [NumReq-1:0]           reqLast,
    output logic [NumReq-1:0]           reqReady,
    output logic                        writeReq,
    output logic [DataWidth-1:0]        writeData,
    output logic                        writeDataValid,
    output logic                        writeDataLast,
    input  logic                        writeDataReady,
    input  logic                        full,
    output logic                        grantValid,
    output logic [IdW-1:0]              grantId,
    output logic [PktCountWidth-1:0]    pktCount
);

    arb_state_t               state_r;
    arb_state_t               nextState_s;
    logic [IdW-1:0]           rrPtr_r;
    logic [IdW-1:0]           grantId_r;
    logic [PktCountWidth-1:0] pktCount_r;
    logic [IdW-1:0]           winner_s;
    logic                     anyValid_s;
    logic                     launch_s;
    logic                     done_s;

    rr_priority_pick #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_pick (
        .valid    (reqValid),
        .ptr      (rrPtr_r),
        .winner   (winner_s),
        .anyValid (anyValid_s)
    );

    // Next-state logic; grant only when FIFO is not full, release on accepted last beat.
    always_comb begin
        nextState_s = state_r;
        launch_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (anyValid_s && !full) begin
                    nextState_s = BUSY;
                    launch_s    = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            BUSY: begin
                if (writeDataValid && writeDataReady && writeDataLast) begin
                    nextState_s = IDLE;
                    done_s      = 1'b1;
                end else begin
                    nextState_s = BUSY;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and packet counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            rrPtr_r    <= '0;
            grantId_r  <= '0;
            pktCount_r <= '0;
        end else begin
            state_r <= nextState_s;
            if (launch_s) begin
                grantId_r <= winner_s;
            end else if (done_s) begin
                grantId_r <= '0;
            end else begin
                grantId_r <= grantId_r;
            end
            if (done_s) begin
                if (grantId_r == IdW'(NumReq - 1)) begin
                    rrPtr_r <= '0;
                end else begin
                    rrPtr_r <= grantId_r + IdW'(1);
                end
                pktCount_r <= pktCount_r + PktCountWidth'(1);
            end else begin
                rrPtr_r    <= rrPtr_r;
                pktCount_r <= pktCount_r;
            end
        end
    end

    // Combinational data path: forward the granted producer, everything zero when idle.
    always_comb begin
        writeData      = '0;
        writeDataValid = 1'b0;
        writeDataLast  = 1'b0;
        reqReady       = '0;
        if (state_r == BUSY) begin
            writeData           = reqData[int'(grantId_r)*DataWidth +: DataWidth];
            writeDataValid      = reqValid[grantId_r];
            writeDataLast       = reqLast[grantId_r];
            reqReady[grantId_r] = writeDataReady;
        end else begin
            writeData      = '0;
            writeDataValid = 1'b0;
            writeDataLast  = 1'b0;
            reqReady       = '0;
        end
    end

    assign writeReq   = (state_r == BUSY);
    assign grantValid = (state_r == BUSY);
    assign grantId    = grantId_r;
    assign pktCount   = pktCount_r;

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Packet-atomic round-robin arbiter that shares the single write port of `fifo_top` among `NumReq` AXI-Stream-style producers (e.g. several `counter_up` sources). A grant is held from the first beat of a packet until its `last` beat is accepted, so packets from different producers never interleave in the FIFO. The block sits directly in front of `fifo_top` and drives its `writeReq`, `writeData`, `writeDataValid` and `writeDataLast` inputs.

## Interface
- `DataWidth`, 32, beat width; must match `fifo_top`.
- `NumReq`, 2, number of producers (2..8).
- `clk`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `reqData`  in  NumReq*DataWidth  producer data; producer i occupies bits `[i*DataWidth +: DataWidth]`.
- `reqValid`  in  NumReq  per-producer beat valid.
- `reqLast`  in  NumReq  per-producer last beat of packet.
- `reqReady`  out  NumReq  per-producer ready; only the granted bit can be 1.
- `writeReq`  out  1  to FIFO; high while a grant is held.
- `writeData`  out  DataWidth  to FIFO; granted producer's data.
- `writeDataValid`  out  1  to FIFO; granted producer's valid.
- `writeDataLast`  out  1  to FIFO; granted producer's last.
- `writeDataReady`  in  1  from FIFO.
- `full`  in  1  from FIFO.
- `grantValid`  out  1  a grant is held.
- `grantId`  out  $clog2(NumReq)  index of the granted producer; 0 when idle.
- `pktCount`  out  16  completed packets, all producers combined.

## Operation
- FSM with two states:
  - IDLE: no grant.
  - BUSY: grant held for `grantId`.
- IDLE -> BUSY: when any `reqValid` is 1 and `full` is 0.
  - The winner is the first set `reqValid` bit at or above `rrPtr`, searching upward and wrapping modulo NumReq.
  - `grantId` is registered with the winner.
- BUSY, data path:
  - `writeReq`=1.
  - `writeData`, `writeDataValid` and `writeDataLast` are muxed combinationally from producer `grantId`.
  - `reqReady[grantId]` = `writeDataReady`; all other `reqReady` bits are 0.
- Beat accepted when `writeDataValid && writeDataReady`.
- BUSY -> IDLE: when the accepted beat has `writeDataLast` set. On that edge:
  - `rrPtr` <= (`grantId`+1) mod NumReq.
  - `pktCount` increments, wrapping 0xFFFF -> 0.
- IDLE outputs: `writeReq`, `writeDataValid`, `writeDataLast` and all `reqReady` bits are 0; `writeData`=0.
- Reset: `state`=IDLE, `rrPtr`=0, `grantId`=0, `pktCount`=0, every output 0.
- Reset mid-packet: the grant is dropped immediately. The partial packet already written to the FIFO is not repaired; flushing it is the FIFO's responsibility.
- `full` is checked only when granting. Inside a packet, backpressure comes solely from `writeDataReady`.
- A valid drop by the granted producer mid-packet does not release the grant; the arbiter waits.
- Requests from non-granted producers are ignored while BUSY; their `reqReady` stays 0.

## Timing
- Arbitration takes 1 cycle: request seen in IDLE at edge k, so BUSY and `grantId` are valid after edge k.
- First beat can transfer in the first BUSY cycle.
- An N-beat packet with no backpressure occupies N+1 cycles, including the IDLE arbitration cycle.
- Back-to-back packets always have one IDLE cycle between them.
- Single-beat packets (valid and last on the first beat) are legal: the block returns to IDLE after 1 BUSY cycle.
- No registers sit in the data path; the `reqData` to `writeData` path is combinational through the mux.

## Structure
- Package `fifo_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY);
  - the `PktCountWidth`=16 constant;
  - a function `rr_pick(valid, ptr)` that returns the winner index.
- One sub-module, `rr_priority_pick`, is natural: a combinational rotate / priority-encode / un-rotate picker that the FSM instantiates once.

## Test plan
- Single producer, 3-beat packet (data 1,2,3; last on beat 3), `writeDataReady`=1:
  - `grantId`=0 one cycle after `reqValid[0]` rises.
  - Beats appear on `writeData` on 3 consecutive cycles.
  - IDLE follows; `pktCount`=1.
- Both producers request continuously with 2-beat packets:
  - Grants alternate 0,1,0,1.
  - `pktCount`=4 after 12 cycles.
  - The FIFO never holds interleaved beats.
- `writeDataReady` held low for 5 cycles mid-packet:
  - Grant held throughout; `reqReady[grantId]`=0 and the data is stable.
  - The packet completes after ready returns.
- `full`=1 in IDLE with both requests valid:
  - No grant; `writeReq`=0.
  - `full` drops -> grant is issued to `rrPtr` on the next edge.
- `reset` asserted on beat 2 of a 4-beat packet:
  - Next cycle: IDLE, `grantId`=0, `pktCount`=0, all `reqReady`=0.
- Wrap checks:
  - Preload 65535 packets, then complete one more -> `pktCount`=0.
  - With NumReq=3 and `rrPtr`=2 and producers 0,1 valid -> winner is 0.
